// File: rtl/riscv_core_pkg.sv
// -----------------------------------------------------------------------------
// riscv_core_pkg
// Shared definitions for the RV32I Decode/Execute slice:
//   - RV32I major opcode constants
//   - alu_op_e      : ALU operation selector
//   - opa_sel_e     : ALU operand A source (zero / rs1 / pc)
//   - opb_sel_e     : ALU operand B source (rs2 / immediate / constant 4)
//   - idex_t        : ID/EX pipeline register contents
//   - arith_op()    : funct3 -> ALU operation for OP and OP-IMM
// -----------------------------------------------------------------------------
package riscv_core_pkg;

    localparam int unsigned XLEN = 32;

    localparam logic [6:0] OP_R      = 7'b0110011;
    localparam logic [6:0] OP_IMM    = 7'b0010011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;

    // ALU_NONE is the all-zero encoding so a cleared ID/EX register is a bubble.
    typedef enum logic [3:0] {
        ALU_NONE,
        ALU_ADD,
        ALU_SUB,
        ALU_SLL,
        ALU_SLT,
        ALU_SLTU,
        ALU_XOR,
        ALU_SRL,
        ALU_SRA,
        ALU_OR,
        ALU_AND
    } alu_op_e;

    typedef enum logic [1:0] {
        OPA_ZERO,
        OPA_RS1,
        OPA_PC
    } opa_sel_e;

    typedef enum logic [1:0] {
        OPB_RS2,
        OPB_IMM,
        OPB_FOUR
    } opb_sel_e;

    typedef struct packed {
        logic [XLEN-1:0] rs1_val;
        logic [XLEN-1:0] rs2_val;
        logic [XLEN-1:0] imm;
        logic [XLEN-1:0] pc;
        alu_op_e         alu_op;
        opa_sel_e        a_sel;
        opb_sel_e        b_sel;
    } idex_t;

    // alt selects SUB (funct3=000) or SRA (funct3=101); the caller decides
    // whether instr[30] is meaningful for the given opcode.
    function automatic alu_op_e arith_op(input logic [2:0] funct3, input logic alt);
        alu_op_e op;
        case (funct3)
            3'b000:  op = alt ? ALU_SUB : ALU_ADD;
            3'b001:  op = ALU_SLL;
            3'b010:  op = ALU_SLT;
            3'b011:  op = ALU_SLTU;
            3'b100:  op = ALU_XOR;
            3'b101:  op = alt ? ALU_SRA : ALU_SRL;
            3'b110:  op = ALU_OR;
            default: op = ALU_AND;
        endcase
        return op;
    endfunction

endpackage

// File: rtl/riscv_core_register_file.sv
// -----------------------------------------------------------------------------
// register_file
// 32 x DATA_WIDTH integer register file, x0 hard-wired to zero.
// Synchronous write on rising clk when we=1 (writes to x0 dropped),
// combinational reads on two ports, asynchronous active-low clear.
// Optional macro RISCV_CORE_WB_BYPASS_EN: a read of the register being
// written this cycle returns wr_data (write-through).
// Ports:
//   clk, rst_n                    clock, async active-low reset
//   we, wr_addr, wr_data          write port
//   rs1_addr/rs1_data             read port 1
//   rs2_addr/rs2_data             read port 2
// -----------------------------------------------------------------------------
module register_file #(
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned ADDR_WIDTH = 5
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  we,
    input  logic [ADDR_WIDTH-1:0] wr_addr,
    input  logic [DATA_WIDTH-1:0] wr_data,
    input  logic [ADDR_WIDTH-1:0] rs1_addr,
    input  logic [ADDR_WIDTH-1:0] rs2_addr,
    output logic [DATA_WIDTH-1:0] rs1_data,
    output logic [DATA_WIDTH-1:0] rs2_data
);

    localparam int unsigned NUM_REGS = 1 << ADDR_WIDTH;

    logic [DATA_WIDTH-1:0] regs [NUM_REGS];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int unsigned i = 0; i < NUM_REGS; i++) begin
                regs[i] <= '0;
            end
        end else if (we && (wr_addr != '0)) begin
            regs[wr_addr] <= wr_data;
        end
    end

    always_comb begin
        rs1_data = '0;
        rs2_data = '0;
`ifdef RISCV_CORE_WB_BYPASS_EN
        if (rs1_addr != '0) begin
            rs1_data = (we && (wr_addr == rs1_addr)) ? wr_data : regs[rs1_addr];
        end
        if (rs2_addr != '0) begin
            rs2_data = (we && (wr_addr == rs2_addr)) ? wr_data : regs[rs2_addr];
        end
`else
        if (rs1_addr != '0) begin
            rs1_data = regs[rs1_addr];
        end
        if (rs2_addr != '0) begin
            rs2_data = regs[rs2_addr];
        end
`endif
    end

endmodule

// File: rtl/riscv_core.sv
// -----------------------------------------------------------------------------
// riscv_core
// Two-stage Decode/Execute slice of an RV32I pipeline.
//   IF/ID register -> combinational decode + register read -> ID/EX register
//   -> combinational ALU. Result valid shortly after the second rising edge
//   following presentation of an instruction. Unknown opcodes are bubbles.
// Optional macro RISCV_CORE_WB_BYPASS_EN: register-file write-through.
// Ports:
//   clk, rst_n                        clock, async active-low reset
//   instruction_i, pc_i               instruction word and its PC from fetch
//   WB_we, WB_wr_addr, WB_wr_data     register file write-back port
//   alu_result_o                      execute-stage ALU result
//   alu_zeroFlag_o                    high when alu_result_o == 0
// -----------------------------------------------------------------------------
module riscv_core
    import riscv_core_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned ADDR_WIDTH = 5
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [DATA_WIDTH-1:0] instruction_i,
    input  logic [DATA_WIDTH-1:0] pc_i,
    input  logic                  WB_we,
    input  logic [ADDR_WIDTH-1:0] WB_wr_addr,
    input  logic [DATA_WIDTH-1:0] WB_wr_data,
    output logic [DATA_WIDTH-1:0] alu_result_o,
    output logic                  alu_zeroFlag_o
);

    logic [DATA_WIDTH-1:0] ifid_instr;
    logic [DATA_WIDTH-1:0] ifid_pc;
    logic [DATA_WIDTH-1:0] rs1_data;
    logic [DATA_WIDTH-1:0] rs2_data;
    idex_t                 dec;
    idex_t                 idex_q;

    // IF/ID
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ifid_instr <= '0;
            ifid_pc    <= '0;
        end else begin
            ifid_instr <= instruction_i;
            ifid_pc    <= pc_i;
        end
    end

    register_file #(
        .DATA_WIDTH (DATA_WIDTH),
        .ADDR_WIDTH (ADDR_WIDTH)
    ) u_register_file (
        .clk      (clk),
        .rst_n    (rst_n),
        .we       (WB_we),
        .wr_addr  (WB_wr_addr),
        .wr_data  (WB_wr_data),
        .rs1_addr (ifid_instr[19:15]),
        .rs2_addr (ifid_instr[24:20]),
        .rs1_data (rs1_data),
        .rs2_data (rs2_data)
    );

    // Decode
    logic [6:0]            opcode;
    logic [2:0]            funct3;
    logic [DATA_WIDTH-1:0] imm_i, imm_s, imm_b, imm_u, imm_j;

    assign opcode = ifid_instr[6:0];
    assign funct3 = ifid_instr[14:12];
    assign imm_i  = {{20{ifid_instr[31]}}, ifid_instr[31:20]};
    assign imm_s  = {{20{ifid_instr[31]}}, ifid_instr[31:25], ifid_instr[11:7]};
    assign imm_b  = {{19{ifid_instr[31]}}, ifid_instr[31], ifid_instr[7],
                     ifid_instr[30:25], ifid_instr[11:8], 1'b0};
    assign imm_u  = {ifid_instr[31:12], 12'b0};
    assign imm_j  = {{11{ifid_instr[31]}}, ifid_instr[31], ifid_instr[19:12],
                     ifid_instr[20], ifid_instr[30:21], 1'b0};

    always_comb begin
        dec         = '0;
        dec.rs1_val = rs1_data;
        dec.rs2_val = rs2_data;
        dec.pc      = ifid_pc;
        dec.alu_op  = ALU_NONE;
        dec.a_sel   = OPA_ZERO;
        dec.b_sel   = OPB_RS2;
        case (opcode)
            OP_R: begin
                dec.alu_op = arith_op(funct3, ifid_instr[30]);
                dec.a_sel  = OPA_RS1;
            end
            OP_IMM: begin
                // instr[30] only distinguishes SRAI from SRLI; ADDI has no SUB form.
                dec.alu_op = arith_op(funct3, (funct3 == 3'b101) && ifid_instr[30]);
                dec.a_sel  = OPA_RS1;
                dec.b_sel  = OPB_IMM;
                dec.imm    = imm_i;
            end
            OP_LOAD: begin
                dec.alu_op = ALU_ADD;
                dec.a_sel  = OPA_RS1;
                dec.b_sel  = OPB_IMM;
                dec.imm    = imm_i;
            end
            OP_STORE: begin
                dec.alu_op = ALU_ADD;
                dec.a_sel  = OPA_RS1;
                dec.b_sel  = OPB_IMM;
                dec.imm    = imm_s;
            end
            OP_BRANCH: begin
                dec.a_sel = OPA_RS1;
                dec.imm   = imm_b;
                case (funct3)
                    3'b000, 3'b001: dec.alu_op = ALU_SUB;
                    3'b100, 3'b101: dec.alu_op = ALU_SLT;
                    3'b110, 3'b111: dec.alu_op = ALU_SLTU;
                    default:        dec.alu_op = ALU_NONE;
                endcase
            end
            OP_LUI: begin
                dec.alu_op = ALU_ADD;
                dec.b_sel  = OPB_IMM;
                dec.imm    = imm_u;
            end
            OP_AUIPC: begin
                dec.alu_op = ALU_ADD;
                dec.a_sel  = OPA_PC;
                dec.b_sel  = OPB_IMM;
                dec.imm    = imm_u;
            end
            OP_JAL: begin
                dec.alu_op = ALU_ADD;
                dec.a_sel  = OPA_PC;
                dec.b_sel  = OPB_FOUR;
                dec.imm    = imm_j;
            end
            OP_JALR: begin
                dec.alu_op = ALU_ADD;
                dec.a_sel  = OPA_PC;
                dec.b_sel  = OPB_FOUR;
                dec.imm    = imm_i;
            end
            default: dec.alu_op = ALU_NONE;
        endcase
    end

    // ID/EX
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            idex_q <= '0;
        end else begin
            idex_q <= dec;
        end
    end

    // Execute
    logic [DATA_WIDTH-1:0] op_a, op_b;
    logic [4:0]            shamt;

    always_comb begin
        op_a = '0;
        case (idex_q.a_sel)
            OPA_RS1: op_a = idex_q.rs1_val;
            OPA_PC:  op_a = idex_q.pc;
            default: op_a = '0;
        endcase
        op_b = idex_q.rs2_val;
        case (idex_q.b_sel)
            OPB_IMM:  op_b = idex_q.imm;
            OPB_FOUR: op_b = DATA_WIDTH'(4);
            default:  op_b = idex_q.rs2_val;
        endcase
    end

    assign shamt = op_b[4:0];

    always_comb begin
        alu_result_o = '0;
        case (idex_q.alu_op)
            ALU_ADD:  alu_result_o = op_a + op_b;
            ALU_SUB:  alu_result_o = op_a - op_b;
            ALU_SLL:  alu_result_o = op_a << shamt;
            ALU_SLT:  alu_result_o[0] = $signed(op_a) < $signed(op_b);
            ALU_SLTU: alu_result_o[0] = op_a < op_b;
            ALU_XOR:  alu_result_o = op_a ^ op_b;
            ALU_SRL:  alu_result_o = op_a >> shamt;
            ALU_SRA:  alu_result_o = $unsigned($signed(op_a) >>> shamt);
            ALU_OR:   alu_result_o = op_a | op_b;
            ALU_AND:  alu_result_o = op_a & op_b;
            default:  alu_result_o = '0;
        endcase
    end

    assign alu_zeroFlag_o = (alu_result_o == '0);

endmodule

// File: tb/tb_riscv_core.sv
// -----------------------------------------------------------------------------
// tb_riscv_core
// Directed bench for riscv_core: write registers through the WB port, issue
// single instructions and compare the ALU result/zero flag against
// hand-computed values. Honors RISCV_CORE_WB_BYPASS_EN for the same-cycle
// write/read case.
// -----------------------------------------------------------------------------
module tb_riscv_core;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [31:0] instruction_i;
    logic [31:0] pc_i;
    logic        WB_we;
    logic [4:0]  WB_wr_addr;
    logic [31:0] WB_wr_data;
    logic [31:0] alu_result_o;
    logic        alu_zeroFlag_o;

    int n_cmp = 0;
    int n_err = 0;

    riscv_core #(
        .DATA_WIDTH (32),
        .ADDR_WIDTH (5)
    ) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .instruction_i  (instruction_i),
        .pc_i           (pc_i),
        .WB_we          (WB_we),
        .WB_wr_addr     (WB_wr_addr),
        .WB_wr_data     (WB_wr_data),
        .alu_result_o   (alu_result_o),
        .alu_zeroFlag_o (alu_zeroFlag_o)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wb_write(input logic [4:0] addr, input logic [31:0] data);
        WB_we      = 1'b1;
        WB_wr_addr = addr;
        WB_wr_data = data;
        tick();
        WB_we      = 1'b0;
        WB_wr_addr = '0;
        WB_wr_data = '0;
    endtask

    // Present for one edge, then feed a bubble; result is observed after the second edge.
    task automatic issue(input logic [31:0] instr, input logic [31:0] pc);
        instruction_i = instr;
        pc_i          = pc;
        tick();
        instruction_i = '0;
        pc_i          = '0;
        tick();
    endtask

    task automatic expect_alu(input string tag, input logic [31:0] exp_res);
        check({tag, "_res"}, alu_result_o, exp_res);
        check({tag, "_zf"}, {31'b0, alu_zeroFlag_o}, {31'b0, exp_res == 32'h0});
    endtask

    initial begin
        rst_n         = 1'b0;
        instruction_i = '0;
        pc_i          = '0;
        WB_we         = 1'b0;
        WB_wr_addr    = '0;
        WB_wr_data    = '0;
        #12;
        check("reset_res", alu_result_o, 32'h0);
        check("reset_zf", {31'b0, alu_zeroFlag_o}, 32'h1);
        rst_n = 1'b1;
        tick();
        tick();
        check("idle_res", alu_result_o, 32'h0);

        wb_write(5'd1, 32'd100);
        wb_write(5'd2, 32'd200);

        issue(32'h002081b3, 32'h0);  expect_alu("add", 32'd300);
        issue(32'h03208213, 32'h0);  expect_alu("addi", 32'd150);
        issue(32'h401102b3, 32'h0);  expect_alu("sub", 32'd100);
        issue(32'h40108333, 32'h0);  expect_alu("sub_zero", 32'd0);
        issue(32'h00c0a383, 32'h0);  expect_alu("lw", 32'd112);
        issue(32'h00108063, 32'h0);  expect_alu("beq", 32'd0);

        wb_write(5'd0, 32'd55);
        issue(32'h000001b3, 32'h0);  expect_alu("x0_add", 32'd0);

        wb_write(5'd1, 32'hFFFF_FFF8);
        issue(32'h4010D193, 32'h0);  expect_alu("srai", 32'hFFFF_FFFC);
        issue(32'h0020B1B3, 32'h0);  expect_alu("sltu", 32'd0);
        issue(32'h0020A1B3, 32'h0);  expect_alu("slt", 32'd1);
        issue(32'h0020D1B3, 32'h0);  expect_alu("srl", 32'h00FF_FFFF);
        issue(32'h4020D1B3, 32'h0);  expect_alu("sra", 32'hFFFF_FFFF);
        issue(32'h00001197, 32'h1000); expect_alu("auipc", 32'h0000_2000);
        issue(32'h123451B7, 32'h0);  expect_alu("lui", 32'h1234_5000);
        issue(32'h0000006F, 32'h40); expect_alu("jal", 32'h0000_0044);
        issue(32'h00000000, 32'h80); expect_alu("bubble", 32'd0);
        issue(32'hFFFFFFFF, 32'h80); expect_alu("unknown", 32'd0);

        // add x3,x2,x0 decoded in the same cycle that x2 is being rewritten.
        instruction_i = 32'h000101b3;
        tick();
        instruction_i = '0;
        WB_we      = 1'b1;
        WB_wr_addr = 5'd2;
        WB_wr_data = 32'd7;
        tick();
        WB_we      = 1'b0;
        WB_wr_addr = '0;
        WB_wr_data = '0;
`ifdef RISCV_CORE_WB_BYPASS_EN
        expect_alu("same_cycle", 32'd7);
`else
        expect_alu("same_cycle", 32'd200);
`endif
        issue(32'h000101b3, 32'h0);  expect_alu("after_write", 32'd7);

        // Reset in the middle of an in-flight add.
        wb_write(5'd1, 32'd100);
        wb_write(5'd2, 32'd200);
        instruction_i = 32'h002081b3;
        tick();
        tick();
        expect_alu("pre_reset", 32'd300);
        #2 rst_n = 1'b0;
        #1;
        check("async_reset_res", alu_result_o, 32'h0);
        check("async_reset_zf", {31'b0, alu_zeroFlag_o}, 32'h1);
        #1 rst_n = 1'b1;
        issue(32'h002081b3, 32'h0);  expect_alu("regs_cleared", 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
